fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the decode stage.
//  - Owns the program counter (PC) and issues word reads to program memory over a req/valid handshake.
//  - Buffers returned 16-bit instruction words in a 2-entry queue and presents them, with their PC, to decode over valid/ready.
//  - Handles branch redirects: flushes queued words and discards any in-flight memory response.

---
 rtl/fetch_unit_pkg.sv | 9 +
 rtl/fetch_queue.sv | 34 +++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage widths, FSM state encodings and the nop word
package fetch_unit_pkg;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 10;
    localparam logic [1:0] FETCH_S_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_S_REQ   = 2'd1;
    localparam logic [1:0] FETCH_S_DRAIN = 2'd2;
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instruction} with flush; entry 0 is always the head
module fetch_queue #(
    parameter int W = 26
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q;
    logic [1:0]   wr_idx;
    assign wr_idx  = count_q - 2'(pop_i);
    assign count_o = count_q;
    assign head_o  = mem_q[0];
    // a simultaneous pop shifts the tail forward, so the push lands one slot lower
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            if (pop_i) mem_q[0] <= mem_q[1];
            if (push_i) mem_q[wr_idx[0]] <= data_i;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one-at-a-time program-memory reads and queues
// returned words for decode; branch redirects flush the queue and drop in-flight data
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int PC_WIDTH    = PC_W,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    output logic                   pmem_req_o,
    output logic [PC_WIDTH-1:0]    pmem_addr_o,
    input  logic                   pmem_valid_i,
    input  logic [INSTR_WIDTH-1:0] pmem_rdata_i,
    input  logic                   branch_en_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic [PC_WIDTH-1:0]    pc_out_o
);
    logic [1:0]                      state_q, state_d;
    logic [PC_WIDTH-1:0]             pc_q, pc_d, addr_q, addr_d, pc_inc;
    logic [1:0]                      count, cnt_nx;
    logic [PC_WIDTH+INSTR_WIDTH-1:0] head;
    logic                            push, pop;
    assign push          = state_q == FETCH_S_REQ && pmem_valid_i && !branch_en_i;
    assign pop           = instr_valid_o && instr_ready_i && !branch_en_i;
    assign cnt_nx        = count + 2'(push) - 2'(pop);
    assign pc_inc        = pc_q + 1'b1;
    assign pmem_req_o    = state_q != FETCH_S_IDLE;
    assign pmem_addr_o   = addr_q;
    assign instr_valid_o = count != 2'd0;
    assign instruction_o = instr_valid_o ? head[INSTR_WIDTH-1:0] : INSTR_WIDTH'(NOP_WORD);
    assign pc_out_o      = instr_valid_o ? head[PC_WIDTH+INSTR_WIDTH-1:INSTR_WIDTH] : '0;
    fetch_queue #(.W(PC_WIDTH + INSTR_WIDTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_en_i),
        .data_i  ({pc_q, pmem_rdata_i}),
        .count_o (count),
        .head_o  (head)
    );
    // requests are gated on post-cycle occupancy so a response never meets a full queue
    always_comb begin
        state_d = state_q;
        pc_d    = branch_en_i ? branch_target_i : pc_q;
        addr_d  = addr_q;
        if (state_q == FETCH_S_IDLE) begin
            if (branch_en_i || cnt_nx < 2'd2) begin
                state_d = FETCH_S_REQ;
                addr_d  = branch_en_i ? branch_target_i : pc_q;
            end
        end else if (state_q == FETCH_S_REQ) begin
            if (branch_en_i) begin
                state_d = pmem_valid_i ? FETCH_S_IDLE : FETCH_S_DRAIN;
            end else if (pmem_valid_i) begin
                pc_d    = pc_inc;
                addr_d  = pc_inc;
                state_d = cnt_nx < 2'd2 ? FETCH_S_REQ : FETCH_S_IDLE;
            end
        end else if (pmem_valid_i) begin
            state_d = FETCH_S_IDLE;
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= FETCH_S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios with a latency-programmable memory model
// and a scoreboard monitor that checks every word accepted by decode
module tb_fetch_unit;
    localparam int IW = 16;
    localparam int PW = 10;
    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pmem_req, pmem_valid = 1'b0;
    logic [PW-1:0] pmem_addr;
    logic [IW-1:0] pmem_rdata = '0;
    logic          branch_en = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic          instr_valid, instr_ready = 1'b0;
    logic [IW-1:0] instruction;
    logic [PW-1:0] pc_out;
    int            lat = 0;
    int            wcnt = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [PW+IW-1:0] sb[$];
    logic          p_req = 1'b0, p_vld = 1'b0;
    logic [PW-1:0] p_addr = '0;

    fetch_unit dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .pmem_req_o      (pmem_req),
        .pmem_addr_o     (pmem_addr),
        .pmem_valid_i    (pmem_valid),
        .pmem_rdata_i    (pmem_rdata),
        .branch_en_i     (branch_en),
        .branch_target_i (branch_target),
        .instr_valid_o   (instr_valid),
        .instr_ready_i   (instr_ready),
        .instruction_o   (instruction),
        .pc_out_o        (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mdata(input logic [PW-1:0] a);
        return {6'h2d, a};
    endfunction

    function automatic logic [PW+IW-1:0] ent(input logic [PW-1:0] a);
        return {a, mdata(a)};
    endfunction

    // memory: answers a held request after 'lat' wait cycles (0 = same cycle)
    always @(posedge clk) begin
        #1;
        if (!rst_n || !pmem_req || pmem_valid) wcnt = 0;
        if (rst_n && pmem_req && wcnt >= lat) begin
            pmem_valid = 1'b1;
            pmem_rdata = mdata(pmem_addr);
        end else begin
            pmem_valid = 1'b0;
            if (rst_n && pmem_req) wcnt++;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !branch_en) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected word: got pc=%0h instr=%0h, required none", pc_out, instruction);
            end else begin
                logic [PW+IW-1:0] e;
                e = sb.pop_front();
                if ({pc_out, instruction} !== e) begin
                    n_err++;
                    $display("FAIL word: got pc=%0h instr=%0h, required pc=%0h instr=%0h",
                             pc_out, instruction, e[PW+IW-1:IW], e[IW-1:0]);
                end
            end
        end
    end

    // request must stay asserted with a stable address until a response completes it
    always @(negedge clk) begin
        if (rst_n && p_req && !p_vld) begin
            n_vec++;
            if (pmem_req !== 1'b1 || pmem_addr !== p_addr) begin
                n_err++;
                $display("FAIL req hold: got req=%0b addr=%0h, required req=1 addr=%0h", pmem_req, pmem_addr, p_addr);
            end
        end
        p_req  = rst_n && pmem_req;
        p_vld  = pmem_valid;
        p_addr = pmem_addr;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, " req"}, 32'(pmem_req), 0);
        chk({tag, " addr"}, 32'(pmem_addr), 0);
        chk({tag, " valid"}, 32'(instr_valid), 0);
        chk({tag, " instr"}, 32'(instruction), 0);
        chk({tag, " pc_out"}, 32'(pc_out), 0);
    endtask

    task automatic wait_sb(input int n, input string name);
        for (int i = 0; i < n && sb.size() != 0; i++) cyc(1);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s delivery: got %0d words outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        ready_off();
        rst_n = 1'b0;
        cyc(2);
    endtask

    task automatic ready_off();
        instr_ready = 1'b0;
        branch_en   = 1'b0;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1 rst_chk("reset");
        cyc(2);
        // 1: zero-wait memory streams one word per cycle
        lat = 0; instr_ready = 1'b1;
        for (int a = 0; a < 4; a++) sb.push_back(ent(PW'(a)));
        rst_n = 1'b1;
        cyc(1); chk("t1 valid cycle1", 32'(instr_valid), 0);
        cyc(1); chk("t1 valid cycle2", 32'(instr_valid), 1); chk("t1 pc cycle2", 32'(pc_out), 0);
        wait_sb(20, "t1");
        do_reset();
        // 2: 3-cycle latency leaves 3-cycle gaps
        lat = 3; instr_ready = 1'b1;
        for (int a = 0; a < 3; a++) sb.push_back(ent(PW'(a)));
        rst_n = 1'b1;
        cyc(5); chk("t2 first valid", 32'(instr_valid), 1); chk("t2 first pc", 32'(pc_out), 0);
        cyc(1); chk("t2 gap", 32'(instr_valid), 0);
        cyc(3); chk("t2 second valid", 32'(instr_valid), 1); chk("t2 second pc", 32'(pc_out), 1);
        wait_sb(30, "t2");
        do_reset();
        // 3: stalled decode fills the queue and stops requests
        lat = 0;
        for (int a = 0; a < 3; a++) sb.push_back(ent(PW'(a)));
        rst_n = 1'b1;
        cyc(3); chk("t3 full req", 32'(pmem_req), 0); chk("t3 full valid", 32'(instr_valid), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1); chk("t3 stall req", 32'(pmem_req), 0); chk("t3 stall pc", 32'(pc_out), 0);
        end
        instr_ready = 1'b1;
        wait_sb(20, "t3");
        do_reset();
        // 4: branch while a request to 0x005 is pending drains and discards it
        lat = 6; instr_ready = 1'b1;
        sb.push_back(ent(10'h100)); sb.push_back(ent(10'h101));
        branch_en = 1'b1; branch_target = 10'h005;
        rst_n = 1'b1;
        cyc(1); branch_en = 1'b0;
        chk("t4 req", 32'(pmem_req), 1); chk("t4 addr", 32'(pmem_addr), 32'h005);
        cyc(3); branch_en = 1'b1; branch_target = 10'h100;
        cyc(1); branch_en = 1'b0;
        chk("t4 drain req", 32'(pmem_req), 1); chk("t4 drain addr", 32'(pmem_addr), 32'h005);
        chk("t4 drain valid", 32'(instr_valid), 0);
        wait_sb(60, "t4");
        do_reset();
        // 5: PC wraps from 0x3FF to 0x000
        lat = 0; instr_ready = 1'b1;
        sb.push_back(ent(10'h3ff)); sb.push_back(ent(10'h000)); sb.push_back(ent(10'h001));
        branch_en = 1'b1; branch_target = 10'h3ff;
        rst_n = 1'b1;
        cyc(1); branch_en = 1'b0;
        wait_sb(20, "t5");
        do_reset();
        // 6: async reset in the middle of a request with a word queued
        lat = 5;
        rst_n = 1'b1;
        cyc(9); chk("t6 pre req", 32'(pmem_req), 1); chk("t6 pre valid", 32'(instr_valid), 1);
        rst_n = 1'b0;
        #1 rst_chk("t6 async");
        cyc(2);
        lat = 0; instr_ready = 1'b1;
        sb.push_back(ent(10'h000)); sb.push_back(ent(10'h001));
        rst_n = 1'b1;
        wait_sb(20, "t6");
        instr_ready = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
